uart_tx_framer: RTL

- Parametrised 8N1-successor UART transmitter for the sensor-link path.
- Configurable data width, parity mode and stop-bit count; baud divisor is derived from clock/baud parameters.
- Valid/ready input handshake with a one-entry holding register, so frames go out back-to-back with no idle gap.
- Sits between the SPN cipher output stage and the board TX pin.

---
 rtl/uart_tx_framer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// UART transmitter: configurable data width, parity and stop bits, with a
// one-entry holding register so consecutive frames leave with no idle gap.
module uart_tx_framer #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int BAUD_W  = $clog2(DIVISOR);
    localparam int BIT_W   = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(DIVISOR - 2);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] hold;
    logic [DATA_BITS-1:0] shifter;
    logic                 hold_full;
    logic                 par_bit;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 bit_end;
    logic                 last_stop;
    logic                 load_par;

    assign tx_ready  = !hold_full;
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign last_stop = (bit_cnt == STOP_LAST);
    // Parity is taken from the held payload so it is fixed before shifting starts.
    assign load_par  = (PARITY == 2) ? ~^hold : ^hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            hold_full  <= 1'b0;
            shifter    <= '0;
            par_bit    <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            uart_tx    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // Registered pulse lands on the final cycle of the last stop bit.
            frame_done <= (state == STOP) && last_stop && (baud_cnt == BAUD_PRE);

            if (tx_valid && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end

            if (state != IDLE)
                baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);

            case (state)
                IDLE: begin
                    if (hold_full) begin
                        state     <= START;
                        uart_tx   <= 1'b0;
                        busy      <= 1'b1;
                        shifter   <= hold;
                        par_bit   <= load_par;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        uart_tx <= shifter[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state   <= PARITY_BIT;
                                uart_tx <= par_bit;
                            end else begin
                                state   <= STOP;
                                uart_tx <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shifter <= shifter >> 1;
                            uart_tx <= shifter[1];
                        end
                    end
                end
                PARITY_BIT: begin
                    if (bit_end) begin
                        state   <= STOP;
                        uart_tx <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!last_stop) begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end else if (hold_full) begin
                            state     <= START;
                            uart_tx   <= 1'b0;
                            shifter   <= hold;
                            par_bit   <= load_par;
                            hold_full <= 1'b0;
                            bit_cnt   <= '0;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
